// File: rtl/acc_writeback_pkg.sv
// Shared accelerator write-back definitions: FSM encoding, sizing defaults
// and the byte stride between consecutive result words.
package acc_writeback_pkg;

    localparam int FIFO_DEPTH_DEFAULT = 16;
    localparam int SLACK_DEFAULT      = 4;

    localparam logic [31:0] ADDR_STRIDE = 32'd4;

    typedef logic [1:0] wb_state_t;

    localparam wb_state_t ST_IDLE  = 2'd0;
    localparam wb_state_t ST_RUN   = 2'd1;
    localparam wb_state_t ST_DRAIN = 2'd2;
    localparam wb_state_t ST_DONE  = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/acc_wb_fifo.sv
// Synchronous result FIFO with a registered head word; a push while full is
// refused (no bypass through a simultaneous pop).
module acc_wb_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_inc;
    logic [CW-1:0] count_reg;
    logic [W-1:0]  head_reg;
    logic          push_ok;
    logic          pop_ok;

    assign empty      = (count_reg == '0);
    assign full       = (count_reg == CW'(DEPTH));
    assign count      = count_reg;
    assign head       = head_reg;
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // Head tracks the next entry; a word entering an (about to be)
            // empty FIFO goes straight to the head register.
            if (pop_ok) begin
                if (count_reg > CW'(1)) begin
                    head_reg <= mem[rd_ptr_inc];
                end else if (push_ok) begin
                    head_reg <= din;
                end
            end else if (push_ok && empty) begin
                head_reg <= din;
            end
        end
    end

endmodule

// File: rtl/acc_writeback.sv
// Buffers accelerator results and writes them to consecutive word addresses,
// throttling the accelerator through bus_free and pulsing done_o per layer.
module acc_writeback
    import acc_writeback_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int SLACK      = SLACK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    input  logic        conv_done_i,
    output logic        bus_free,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        done_o,
    output logic        overflow_o,
    output logic [15:0] word_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FREE_LIMIT = CW'(FIFO_DEPTH - SLACK);

    wb_state_t     state_reg;
    wb_state_t     state_next;
    logic [31:0]   addr_reg;
    logic [15:0]   word_cnt_reg;
    logic          overflow_reg;
    logic          bus_free_reg;
    logic          bus_free_next;

    logic          push_en;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;

    assign push_en    = valid_i && ((state_reg == ST_RUN) || (state_reg == ST_DRAIN));
    assign wr_valid   = !fifo_empty;
    assign pop        = wr_valid && wr_ready;
    assign wr_addr    = addr_reg;
    assign word_cnt   = word_cnt_reg;
    assign overflow_o = overflow_reg;
    assign bus_free   = bus_free_reg;
    assign done_o     = (state_reg == ST_DONE);

    acc_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_en),
        .din   (data_i),
        .pop   (pop),
        .head  (wr_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Occupancy after this cycle's push/pop, mirroring the FIFO's own rules.
    always_comb begin
        count_next = fifo_count;
        unique case ({push_en && !fifo_full, pop})
            2'b10:   count_next = fifo_count + 1'b1;
            2'b01:   count_next = fifo_count - 1'b1;
            default: count_next = fifo_count;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (start)                    state_next = ST_RUN;
            ST_RUN:   if (conv_done_i)              state_next = ST_DRAIN;
            ST_DRAIN: if (fifo_empty && !push_en)   state_next = ST_DONE;
            ST_DONE:                                state_next = ST_IDLE;
            default:                                state_next = ST_IDLE;
        endcase
    end

    assign bus_free_next = ((state_next == ST_RUN) || (state_next == ST_DRAIN))
                           && (count_next <= FREE_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            word_cnt_reg <= '0;
            overflow_reg <= 1'b0;
            bus_free_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bus_free_reg <= bus_free_next;
            if ((state_reg == ST_IDLE) && start) begin
                addr_reg     <= base_addr;
                word_cnt_reg <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (pop) begin
                    addr_reg     <= addr_reg + ADDR_STRIDE;
                    word_cnt_reg <= sat_inc16(word_cnt_reg);
                end
                if (push_en && fifo_full) begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_acc_writeback.sv
// Directed bench for acc_writeback: ordered writes, back-pressure, overflow,
// stalls, coincident end-of-layer, mid-layer reset and address wrap.
module tb_acc_writeback;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] data_i;
    logic        valid_i;
    logic        conv_done_i;
    logic        bus_free;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        done_o;
    logic        overflow_o;
    logic [15:0] word_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [31:0] prev_data  = '0;

    always #5 clk = ~clk;

    acc_writeback dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .conv_done_i (conv_done_i),
        .bus_free    (bus_free),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .done_o      (done_o),
        .overflow_o  (overflow_o),
        .word_cnt    (word_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input logic [31:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    task automatic end_layer();
        conv_done_i = 1'b1;
        tick();
        conv_done_i = 1'b0;
    endtask

    task automatic wait_done(input bit toggle);
        for (int i = 0; i < 200 && !done_o; i++) begin
            if (toggle) wr_ready = ~wr_ready;
            tick();
        end
        chk("done_seen", 32'(done_o), 32'd1);
    endtask

    // Write log plus hold-while-stalled check, sampled mid-cycle.
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stall_valid", 32'(wr_valid), 32'd1);
            chk("stall_addr", wr_addr, prev_addr);
            chk("stall_data", wr_data, prev_data);
        end
        prev_stall = rst_n && wr_valid && !wr_ready;
        prev_addr  = wr_addr;
        prev_data  = wr_data;
        if (rst_n && wr_valid && wr_ready) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            $display("write addr=%h data=%h", wr_addr, wr_data);
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; data_i = '0;
        valid_i = 1'b0; conv_done_i = 1'b0; wr_ready = 1'b0;
        tick();
        tick();
        chk("rst_bus_free", 32'(bus_free), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_overflow", 32'(overflow_o), 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic layer: 8 words streamed with the bus always ready.
        wr_ready = 1'b1;
        start_layer(32'h0000_1000);
        chk("s1_bus_free", 32'(bus_free), 32'd1);
        chk("s1_first_valid", 32'(wr_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1;
            data_i  = 32'h0102_0304 + 32'(i) * 32'h0404_0404;
            tick();
            if (i == 0) chk("s1_valid_lat", 32'(wr_valid), 32'd1);
        end
        valid_i = 1'b0;
        end_layer();
        wait_done(1'b0);
        chk("s1_nwr", 32'(wq_addr.size()), 32'd8);
        for (int i = 0; i < 8 && i < wq_addr.size(); i++) begin
            chk($sformatf("s1_addr%0d", i), wq_addr[i], 32'h0000_1000 + 32'(i) * 32'd4);
            chk($sformatf("s1_data%0d", i), wq_data[i], 32'h0102_0304 + 32'(i) * 32'h0404_0404);
        end
        chk("s1_word_cnt", 32'(word_cnt), 32'd8);
        chk("s1_bus_free_done", 32'(bus_free), 32'd0);
        tick();
        chk("s1_done_pulse", 32'(done_o), 32'd0);

        // Back-pressure and overflow with the bus stalled.
        wq_addr.delete(); wq_data.delete();
        wr_ready = 1'b0;
        start_layer(32'h0000_3000);
        for (int k = 1; k <= 16; k++) begin
            valid_i = 1'b1;
            data_i  = 32'hA000_0000 + 32'(k - 1);
            tick();
            chk($sformatf("s2_bus_free_occ%0d", k), 32'(bus_free), 32'(k <= 12));
        end
        chk("s2_no_overflow", 32'(overflow_o), 32'd0);
        data_i = 32'hA000_0010;
        tick();
        valid_i = 1'b0;
        chk("s2_overflow", 32'(overflow_o), 32'd1);
        wr_ready = 1'b1;
        end_layer();
        wait_done(1'b0);
        chk("s2_nwr", 32'(wq_addr.size()), 32'd16);
        for (int i = 0; i < 16 && i < wq_data.size(); i++) begin
            chk($sformatf("s2_data%0d", i), wq_data[i], 32'hA000_0000 + 32'(i));
        end
        chk("s2_word_cnt", 32'(word_cnt), 32'd16);
        chk("s2_overflow_sticky", 32'(overflow_o), 32'd1);
        tick();

        // Ready toggling each cycle under continuous input.
        wq_addr.delete(); wq_data.delete();
        wr_ready = 1'b0;
        start_layer(32'h0000_4000);
        chk("s3_overflow_cleared", 32'(overflow_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            valid_i  = 1'b1;
            data_i   = 32'hC0DE_0000 + 32'(i);
            wr_ready = ~wr_ready;
            tick();
        end
        valid_i = 1'b0;
        end_layer();
        wait_done(1'b1);
        chk("s3_nwr", 32'(wq_addr.size()), 32'd10);
        for (int i = 0; i < 10 && i < wq_addr.size(); i++) begin
            chk($sformatf("s3_addr%0d", i), wq_addr[i], 32'h0000_4000 + 32'(i) * 32'd4);
            chk($sformatf("s3_data%0d", i), wq_data[i], 32'hC0DE_0000 + 32'(i));
        end
        chk("s3_word_cnt", 32'(word_cnt), 32'd10);
        tick();

        // Last word arrives together with the end-of-layer pulse.
        wq_addr.delete(); wq_data.delete();
        wr_ready = 1'b1;
        start_layer(32'h0000_6000);
        valid_i = 1'b1; data_i = 32'h1111_1111;
        tick();
        data_i = 32'h2222_2222; conv_done_i = 1'b1;
        tick();
        valid_i = 1'b0; conv_done_i = 1'b0;
        wait_done(1'b0);
        chk("s4_nwr", 32'(wq_addr.size()), 32'd2);
        if (wq_addr.size() >= 2) begin
            chk("s4_addr1", wq_addr[1], 32'h0000_6004);
            chk("s4_data1", wq_data[1], 32'h2222_2222);
        end
        tick();

        // Reset mid-layer discards buffered words.
        wq_addr.delete(); wq_data.delete();
        wr_ready = 1'b0;
        start_layer(32'h0000_5000);
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; data_i = 32'hBAD0_0000 + 32'(i);
            tick();
        end
        valid_i = 1'b0;
        chk("s5_buffered", 32'(wr_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("s5_wr_valid", 32'(wr_valid), 32'd0);
        chk("s5_bus_free", 32'(bus_free), 32'd0);
        chk("s5_word_cnt", 32'(word_cnt), 32'd0);
        wr_ready = 1'b1;
        tick(); tick(); tick();
        chk("s5_no_writes", 32'(wq_addr.size()), 32'd0);
        start_layer(32'h0000_2000);
        valid_i = 1'b1; data_i = 32'h1234_5678;
        tick();
        valid_i = 1'b0;
        end_layer();
        wait_done(1'b0);
        chk("s5_nwr", 32'(wq_addr.size()), 32'd1);
        if (wq_addr.size() >= 1) begin
            chk("s5_addr0", wq_addr[0], 32'h0000_2000);
            chk("s5_data0", wq_data[0], 32'h1234_5678);
        end
        tick();

        // Address wrap at the top of the 32-bit space.
        wq_addr.delete(); wq_data.delete();
        start_layer(32'hFFFF_FFFC);
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1; data_i = 32'h7700_0000 + 32'(i);
            tick();
        end
        valid_i = 1'b0;
        end_layer();
        wait_done(1'b0);
        chk("s6_nwr", 32'(wq_addr.size()), 32'd2);
        if (wq_addr.size() >= 2) begin
            chk("s6_addr0", wq_addr[0], 32'hFFFF_FFFC);
            chk("s6_addr1", wq_addr[1], 32'h0000_0000);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
